div_32: RTL and testbench



---
 rtl/div_32_if.sv | 28 ++
 rtl/div_32.sv | 147 ++++++++++++++
 tb/tb_div_32.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/div_32_if.sv
// Handshake and data bundle for the sequential divider.
// master drives start/operands, slave returns results and flags.
interface div_32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;
    logic             zero_flag;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder,
        input  div_by_zero, overflow, zero_flag
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder,
        output div_by_zero, overflow, zero_flag
    );
endinterface

// File: rtl/div_32.sv
// Restoring sequential divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands and overflow flag.
module div_32 #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    div_32_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, q_q, d_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] quo_q, rem_q;
    logic             zdiv_q, dbz_q, zf_q;

    logic [WIDTH-1:0] a_d, q_d;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH+1:0] trial;
    logic             step_ok;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] quo_fin, rem_fin;
    logic             dvs_zero;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic qneg_q, rneg_q, ovf_p_q, ovf_q;
`endif

    assign dvs_zero = (bus.divisor == '0);

    always_comb begin
        dvd_mag = bus.dividend;
        dvs_mag = bus.divisor;
`ifdef DIV_SIGNED_EN
        if (bus.dividend[WIDTH-1]) dvd_mag = -bus.dividend;
        if (bus.divisor[WIDTH-1])  dvs_mag = -bus.divisor;
`endif
    end

    // Shifted partial remainder can reach WIDTH+1 bits for large divisors.
    always_comb begin
        a_sh    = {a_q, q_q[WIDTH-1]};
        trial   = {1'b0, a_sh} + {2'b11, ~d_q} + (WIDTH+2)'(1);
        step_ok = ~trial[WIDTH+1];
        a_d     = step_ok ? trial[WIDTH-1:0] : a_sh[WIDTH-1:0];
        q_d     = {q_q[WIDTH-2:0], step_ok};
    end

    always_comb begin
        quo_fin = q_q;
        rem_fin = a_q;
        if (zdiv_q) begin
            quo_fin = '1;
            rem_fin = q_q;
        end
`ifdef DIV_SIGNED_EN
        else begin
            if (qneg_q) quo_fin = -q_q;
            if (rneg_q) rem_fin = -a_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            zdiv_q  <= 1'b0;
            dbz_q   <= 1'b0;
            zf_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovf_p_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    // done_q high means this is the done cycle: no accept.
                    if (bus.start && !done_q) begin
                        busy_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        zf_q    <= 1'b0;
                        zdiv_q  <= dvs_zero;
                        a_q     <= '0;
                        d_q     <= dvs_mag;
                        q_q     <= dvs_zero ? bus.dividend : dvd_mag;
                        cnt_q   <= '0;
                        state_q <= dvs_zero ? DONE : RUN;
`ifdef DIV_SIGNED_EN
                        ovf_q   <= 1'b0;
                        qneg_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        rneg_q  <= bus.dividend[WIDTH-1];
                        ovf_p_q <= (bus.dividend == SMIN) && (bus.divisor == '1);
`endif
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) state_q <= DONE;
                end
                DONE: begin
                    quo_q   <= quo_fin;
                    rem_q   <= rem_fin;
                    dbz_q   <= zdiv_q;
                    zf_q    <= !zdiv_q && (quo_fin == '0);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef DIV_SIGNED_EN
                    ovf_q   <= ovf_p_q && !zdiv_q;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.zero_flag   = zf_q;
`ifdef DIV_SIGNED_EN
    assign bus.overflow    = ovf_q;
`else
    assign bus.overflow    = 1'b0;
`endif
endmodule

// File: tb/tb_div_32.sv
// Scoreboard bench for div_32: expected results queued at start,
// popped and compared when done pulses.
module tb_div_32;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        zf;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    div_32_if #(.WIDTH(32)) bus();

    div_32 #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dbz = 1'b1;
            e.zf  = 1'b0;
            return e;
        end
`ifdef DIV_SIGNED_EN
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q   = 32'h8000_0000;
            e.r   = 32'd0;
            e.ovf = 1'b1;
        end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end
`else
        e.q = a / b;
        e.r = a % b;
`endif
        e.zf = (e.q == 32'd0);
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".q"},   bus.quotient, e.q);
        chk({tag, ".r"},   bus.remainder, e.r);
        chk({tag, ".dbz"}, 32'(bus.div_by_zero), 32'(e.dbz));
        chk({tag, ".zf"},  32'(bus.zero_flag), 32'(e.zf));
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(e.ovf));
    endtask

    // inj >= 0: pulse a competing start of 7/7 that many cycles after E0.
    task automatic run(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input int inj);
        int lat;
        int busy_n;
        int dones;
        exp_t e;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        busy_n = bus.busy ? 1 : 0;
        lat    = 0;
        dones  = 0;
        while (!bus.done && lat < 100) begin
            bus.start = (inj >= 0 && lat == inj);
            if (bus.start) begin
                bus.dividend = 32'd7;
                bus.divisor  = 32'd7;
            end
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) busy_n++;
        end
        bus.start = 1'b0;
        if (lat >= 100) begin
            chk({tag, ".timeout"}, 32'(lat), 32'(exp_lat));
            return;
        end
        chk({tag, ".lat"},  32'(lat), 32'(exp_lat));
        chk({tag, ".busy"}, 32'(busy_n), 32'(exp_lat));
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_out(tag, e);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk({tag, ".extra_done"}, 32'(dones), 32'd0);
    endtask

    initial begin
        int dones;
        bus.start    = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.q",    bus.quotient, 32'd0);
        chk("rst.r",    bus.remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("d100_7",   32'd100, 32'd7, 33, -1);
        run("dmax_1",   32'hFFFF_FFFF, 32'd1, 33, -1);
        run("d3_5",     32'd3, 32'd5, 33, -1);
        run("d5_0",     32'd5, 32'd0, 1, -1);
        run("d9_3",     32'd9, 32'd3, 33, -1);
        run("big_div",  32'hFFFF_FFFF, 32'h8000_0001, 33, -1);
        run("ign_start", 32'd1000, 32'd10, 33, 4);

        // Abort mid-run with reset; no result may surface afterwards.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.done", 32'(bus.done), 32'd0);
        chk("abort.q",    bus.quotient, 32'd0);
        chk("abort.r",    bus.remainder, 32'd0);
        chk("abort.flags",
            32'({bus.div_by_zero, bus.zero_flag, bus.overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("abort.no_done", 32'(dones), 32'd0);
        run("d8_2", 32'd8, 32'd2, 33, -1);

        for (int i = 0; i < 4; i++) begin
            run("rand", $urandom, $urandom_range(1, 70000), 33, -1);
        end

`ifdef DIV_SIGNED_EN
        run("s_m7_2",  32'hFFFF_FFF9, 32'd2, 33, -1);
        run("s_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 33, -1);
        run("s_7_m3",  32'd7, 32'hFFFF_FFFD, 33, -1);
        run("s_m9_0",  32'hFFFF_FFF7, 32'd0, 1, -1);
`endif

        chk("sb.left", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
